// File: rtl/dadda8_mul_arbiter.sv
// dadda8_mul_arbiter: one shared 8x8 unsigned multiplier serving NREQ requesters.
// A round-robin arbiter feeds a two-stage pipeline: an operand register, then
// the combinational multiplier feeding a result register. Results return on a
// single tagged response port with backpressure.

// Combinational 8x8 unsigned multiplier. The partial-product matrix is reduced
// with rows of 3:2 compressors following the Dadda height sequence
// 8 -> 6 -> 4 -> 3 -> 2, then a single carry-propagate add.
module dadda8_orig (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] pp [8];
    logic [15:0] l1 [6];
    logic [15:0] l2 [4];
    logic [15:0] l3 [3];
    logic [15:0] l4 [2];

    genvar gi;

    // Partial products: row gi is a gated by b[gi], shifted into place.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = {8'b0, a & {8{b[gi]}}} << gi;
        end
    endgenerate

    // 8 -> 6 rows: two compressor groups, the last two rows pass through.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_l1
            assign l1[2*gi]   = pp[3*gi] ^ pp[3*gi+1] ^ pp[3*gi+2];
            assign l1[2*gi+1] = ((pp[3*gi] & pp[3*gi+1]) | (pp[3*gi] & pp[3*gi+2])
                               | (pp[3*gi+1] & pp[3*gi+2])) << 1;
        end
    endgenerate
    assign l1[4] = pp[6];
    assign l1[5] = pp[7];

    // 6 -> 4 rows.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_l2
            assign l2[2*gi]   = l1[3*gi] ^ l1[3*gi+1] ^ l1[3*gi+2];
            assign l2[2*gi+1] = ((l1[3*gi] & l1[3*gi+1]) | (l1[3*gi] & l1[3*gi+2])
                               | (l1[3*gi+1] & l1[3*gi+2])) << 1;
        end
    endgenerate

    // 4 -> 3 rows.
    assign l3[0] = l2[0] ^ l2[1] ^ l2[2];
    assign l3[1] = ((l2[0] & l2[1]) | (l2[0] & l2[2]) | (l2[1] & l2[2])) << 1;
    assign l3[2] = l2[3];

    // 3 -> 2 rows.
    assign l4[0] = l3[0] ^ l3[1] ^ l3[2];
    assign l4[1] = ((l3[0] & l3[1]) | (l3[0] & l3[2]) | (l3[1] & l3[2])) << 1;

    // The full product fits in 16 bits, so no carry is lost above bit 15.
    assign p = l4[0] + l4[1];
endmodule

module dadda8_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*8-1:0]   req_a,
    input  logic [NREQ*8-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [15:0]         rsp_data,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);
    logic            s1_valid_q, s1_valid_d;
    logic [7:0]      s1_a_q, s1_a_d;
    logic [7:0]      s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            out_free, s1_adv, s1_free, accept;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [7:0]      sel_a, sel_b;
    logic [15:0]     product;

    dadda8_orig u_mul (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (product)
    );

    assign out_free = !rsp_valid_q | rsp_ready;
    assign s1_adv   = s1_valid_q & out_free;
    assign s1_free  = !s1_valid_q | out_free;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        cand        = 0;
        cand_id     = '0;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        sel_a       = '0;
        sel_b       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_id = cand[ID_W-1:0];
            if (!pick_found && req_valid[cand_id]) begin
                pick_found           = 1'b1;
                pick_idx             = cand_id;
                pick_onehot[cand_id] = 1'b1;
                sel_a                = req_a[cand*8 +: 8];
                sel_b                = req_b[cand*8 +: 8];
            end
        end
    end

    assign req_ready = (s1_free && !rst) ? pick_onehot : '0;
    assign accept    = pick_found & s1_free & !rst;

    // Next-state for operand stage, result stage, pointer and counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = sel_a;
            s1_b_d     = sel_b;
            s1_id_d    = pick_idx;
            rr_ptr_d   = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = product;
            rsp_id_d    = s1_id_q;
        end else if (out_free) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_valid_q && rsp_ready) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any in-flight operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = s1_valid_q | rsp_valid_q;
endmodule
